pipelined_adder_chain: RTL and testbench
========================================

# pipelined_adder_chain

Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes on both sides. The WIDTH-bit operand is split into STAGES equal chunks. Each pipeline stage ripples one chunk through a chain of full adders and registers the carry forward, so the critical path is one chunk wide instead of WIDTH bits. It sits between an operand producer and a result consumer in the arithmetic datapath and sustains one operation per cycle.

## Interface
- WIDTH, 16, operand and sum width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline stages; must be ≥ 1 and divide WIDTH exactly.
- CLK  input  1  rising-edge clock.
- RSTn  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B+cin; 1: A+~B+~cin, i.e. A−B−cin.
- cin  input  1  carry-in when adding, borrow-in when subtracting.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  raw carry out of the MSB. For subtract, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- CHUNK = WIDTH/STAGES. Stage k (0-based) adds bits [k·CHUNK +: CHUNK].
- Input conditioning is combinational at accept:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
- Stage k register contents:
  - valid bit.
  - Sum bits of chunks 0..k, already computed.
  - Not-yet-added A and b_eff bits of chunks k+1..STAGES−1.
  - Carry out of chunk k.
  - Carry into the MSB, in the last stage only.
- The last stage drives sum, cout and ovf.
  - ovf = carry_into_MSB XOR cout.
- Handshake:
  - A beat transfers on valid & ready, both sides.
  - Stage k may load when it is empty, or when its content moves forward this cycle.
  - ready_k = ~valid_k | ready_{k+1}, with ready_STAGES = out_ready.
  - in_ready = ready_0. It is combinational from out_ready through the stage chain.
  - in_valid and the operands must stay stable while in_valid=1 and in_ready=0.
  - out_valid and sum/cout/ovf stay stable while out_valid=1 and out_ready=0.
- Pipeline capacity is STAGES beats. No beat is dropped or duplicated.

## Timing
- Reset (RSTn low, asynchronous): every stage valid = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0. in_ready = 1 whenever RSTn is high and the pipeline is empty.
- Reset mid-operation discards all in-flight beats. The first beat after RSTn rises is accepted on the first edge with in_valid=1.
- Latency: a beat accepted on edge n appears with out_valid=1 after edge n+STAGES−1, given no stalls. STAGES=1 therefore means registered output one cycle after accept.
- Throughput: one beat per cycle while out_ready=1.
- Stall with the pipeline full: in_ready=0 in the same cycle out_ready=0.
- Simultaneous pop and push on a full pipeline is allowed: it advances and accepts in that cycle.
- Bubbles compress: an empty stage accepts from upstream even while downstream stalls.

## Structure
- Shared package adder_pkg holds:
  - a function that derives CHUNK and checks legality (WIDTH % STAGES == 0, STAGES ≥ 1), with an elaboration-time error on violation;
  - the stage-register field layout widths (sum-done, operand-remaining, carry).
- One sub-module, adder_chunk. It is a combinational CHUNK-bit ripple of generate-instantiated full adders. Ports: a, b, ci, s, co, and c_msb (carry into its top bit).
- The top generates STAGES instances of adder_chunk plus the per-stage registers and ready chain.

## Test plan
- WIDTH=16, STAGES=4; a=0xFFFF, b=0x0001, sub=0, cin=0, out_ready=1 -> out_valid 4 cycles later, sum=0x0000, cout=1, ovf=0.
- a=0x8000, b=0x0001, sub=1, cin=0 -> sum=0x7FFF, cout=1, ovf=1. Then a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
- 100 back-to-back random beats, out_ready=1 -> one result per cycle, in order, matching the reference model; in_ready constantly 1.
- Hold out_ready=0 and drive 6 beats -> exactly 4 accepted, in_ready=0 afterward, outputs stable. Release out_ready -> 4 results in order, then the remaining 2.
- Assert RSTn low with 3 beats in flight -> out_valid=0 and sum/cout/ovf=0 immediately. After release, no stale result appears and a fresh beat returns after 4 cycles.
- Re-elaborate with WIDTH=8, STAGES=1 -> 0x7F+0x01 gives sum=0x80, ovf=1, out_valid after 1 cycle. WIDTH=10, STAGES=4 -> elaboration error.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared parameter checks and stage-register field layout for the pipelined adder chain.
package adder_pkg;

  localparam int CARRY_W = 1;

  // Returns the chunk width, or 0 when WIDTH/STAGES cannot be split evenly.
  function automatic int chunk_of(input int width, input int stages);
    if (stages < 1 || width < 2 || (width % stages) != 0) return 0;
    return width / stages;
  endfunction

  // Sum bits already produced once stage k has registered its chunk.
  function automatic int done_w(input int k, input int chunk);
    return (k + 1) * chunk;
  endfunction

  // Operand bits still waiting to be added after stage k.
  function automatic int rem_w(input int k, input int chunk, input int width);
    return width - (k + 1) * chunk;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple of full adders; also exposes the carry into the top bit.
module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/pipelined_adder_chain.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit ripple per stage, carry registered forward,
// valid/ready handshake with a combinational ready chain so bubbles compress.
module pipelined_adder_chain
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_of(WIDTH, STAGES);

  if (CHUNK == 0) begin : g_bad_cfg
    $error("pipelined_adder_chain: WIDTH=%0d STAGES=%0d is not a legal split", WIDTH, STAGES);
  end

  // Subtract is A + ~B + ~borrow, so conditioning happens once at accept.
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? ~cin : cin;
  assign in_ready = g_stage[0].rdy_k;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = rem_w(k - 1, CHUNK, WIDTH);
    localparam int SW = done_w(k, CHUNK);
    localparam int RW = rem_w(k, CHUNK, WIDTH);

    logic               up_vld, ci_up, rdy_k, rdy_dn, ld;
    logic [IW-1:0]      a_up, b_up;
    logic [CHUNK-1:0]   s_c;
    logic               co_c, cmsb_c;
    logic [SW-1:0]      sum_new, sum_d, sum_q;
    logic               vld_d, vld_q;
    logic [CARRY_W-1:0] carry_d, carry_q;

    if (k == 0) begin : g_src
      assign up_vld  = in_valid;
      assign a_up    = a;
      assign b_up    = b_eff;
      assign ci_up   = c0;
      assign sum_new = s_c;
    end else begin : g_src
      assign up_vld  = g_stage[k-1].vld_q;
      assign a_up    = g_stage[k-1].g_rem.a_rem_q;
      assign b_up    = g_stage[k-1].g_rem.b_rem_q;
      assign ci_up   = g_stage[k-1].carry_q[0];
      assign sum_new = {s_c, g_stage[k-1].sum_q};
    end

    if (k == STAGES - 1) begin : g_dn
      assign rdy_dn = out_ready;
    end else begin : g_dn
      assign rdy_dn = g_stage[k+1].rdy_k;
    end

    adder_chunk #(.W(CHUNK)) u_chunk (
      .a     (a_up[CHUNK-1:0]),
      .b     (b_up[CHUNK-1:0]),
      .ci    (ci_up),
      .s     (s_c),
      .co    (co_c),
      .c_msb (cmsb_c)
    );

    assign rdy_k = ~vld_q | rdy_dn;
    assign ld    = rdy_k & up_vld;

    always_comb begin
      vld_d   = rdy_k ? up_vld : vld_q;
      sum_d   = ld ? sum_new : sum_q;
      carry_d = ld ? co_c : carry_q;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        vld_q   <= 1'b0;
        sum_q   <= '0;
        carry_q <= '0;
      end else begin
        vld_q   <= vld_d;
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end

    if (RW > 0) begin : g_rem
      logic [RW-1:0] a_rem_d, a_rem_q, b_rem_d, b_rem_q;

      always_comb begin
        a_rem_d = ld ? a_up[IW-1:CHUNK] : a_rem_q;
        b_rem_d = ld ? b_up[IW-1:CHUNK] : b_rem_q;
      end

      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic cmsb_d, cmsb_q;

      always_comb cmsb_d = ld ? cmsb_c : cmsb_q;

      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) cmsb_q <= 1'b0;
        else       cmsb_q <= cmsb_d;
      end

      assign out_valid = vld_q;
      assign sum       = sum_q;
      assign cout      = carry_q[0];
      assign ovf       = cmsb_q ^ carry_q[0];
    end
  end

endmodule

// File: tb/tb_pipelined_adder_chain.sv
// Directed + random bench with a result scoreboard for the pipelined adder chain.
module tb_pipelined_adder_chain;

  localparam int W = 16;
  localparam int S = 4;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic         in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  logic         in_valid8, in_ready8, sub8, cin8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]   a8, b8, sum8;

  always #5 CLK = ~CLK;

  pipelined_adder_chain #(.WIDTH(W), .STAGES(S)) u_dut (
    .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );

  pipelined_adder_chain #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .sub(sub8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
    .cout(cout8), .ovf(ovf8)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  res_t e;
  int   checks = 0;
  int   errors = 0;
  int   outs   = 0;
  int   stalls = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic ts, input logic tc);
    logic [W-1:0] bb;
    logic [W:0]   full;
    res_t         r;
    bb     = ts ? ~tb : tb;
    full   = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, ts ^ tc};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (ta[W-1] == bb[W-1]) && (r.sum[W-1] != ta[W-1]);
    return r;
  endfunction

  // Transfers are decided at the next rising edge; sample both sides mid-cycle.
  always @(negedge CLK) begin
    if (RSTn === 1'b1) begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, cin));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {31'b0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          outs++;
          check("sb_sum", {16'b0, sum}, {16'b0, e.sum});
          check("sb_cout", {31'b0, cout}, {31'b0, e.cout});
          check("sb_ovf", {31'b0, ovf}, {31'b0, e.ovf});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Presents one beat and returns just after the edge that accepted it.
  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input logic tc);
    a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (in_ready) begin
        @(posedge CLK);
        #1;
        return;
      end
      stalls++;
    end
    checks++;
    errors++;
    $error("FAIL drive_timeout: observed in_ready %0b expected 1", in_ready);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 50; n++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick(1);
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  logic [W-1:0] sa [6];
  logic [W-1:0] sbv[6];
  logic [W-1:0] ra, rb, hold;
  int           acc, idx, sv, outs0;
  logic         took;

  initial begin
    RSTn = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; cin8 = 1'b0; out_ready8 = 1'b1;
    #1 RSTn = 1'b0;
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum", {16'b0, sum}, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    tick(2);
    RSTn = 1'b1;
    #1 check("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // Latency of a lone beat: visible after the third edge following accept.
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick(2);
    check("lat_early", {31'b0, out_valid}, 32'd0);
    tick(1);
    check("lat_valid", {31'b0, out_valid}, 32'd1);
    check("lat_sum", {16'b0, sum}, 32'h0000);
    check("lat_cout", {31'b0, cout}, 32'd1);
    check("lat_ovf", {31'b0, ovf}, 32'd0);
    wait_drain();

    drive(16'h8000, 16'h0001, 1'b1, 1'b0);
    drive(16'h0003, 16'h0005, 1'b1, 1'b0);
    drive(16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
    drive(16'h0000, 16'h0000, 1'b1, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // Back-to-back random traffic.
    stalls = 0;
    outs0  = outs;
    for (int i = 0; i < 100; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      drive(ra, rb, 1'($urandom), 1'($urandom));
    end
    in_valid = 1'b0;
    tick(4);
    check("b2b_stalls", stalls, 32'd0);
    check("b2b_count", outs - outs0, 32'd100);
    wait_drain();

    // Full-pipeline stall: six beats offered, capacity is four.
    sa  = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
    sbv = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000};
    out_ready = 1'b0;
    acc = 0; idx = 0;
    a = sa[0]; b = sbv[0]; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      took = in_ready;
      tick(1);
      if (took) begin
        acc++; idx++;
        if (idx < 6) begin a = sa[idx]; b = sbv[idx]; end
        else in_valid = 1'b0;
      end
    end
    check("stall_acc", acc, 32'd4);
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    check("stall_out_valid", {31'b0, out_valid}, 32'd1);
    hold = sum;
    tick(3);
    check("stall_hold_sum", {16'b0, sum}, {16'b0, hold});
    check("stall_hold_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    for (int n = 0; n < 20 && idx < 6; n++) begin
      @(negedge CLK);
      took = in_ready;
      tick(1);
      if (took) begin
        acc++; idx++;
        if (idx < 6) begin a = sa[idx]; b = sbv[idx]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stall_total", acc, 32'd6);
    wait_drain();

    // Reset with beats in flight flushes everything.
    drive(16'h0101, 16'h0101, 1'b0, 1'b0);
    drive(16'h0202, 16'h0202, 1'b0, 1'b0);
    drive(16'h0303, 16'h0303, 1'b0, 1'b0);
    drive(16'h0404, 16'h0404, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    RSTn = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_sum", {16'b0, sum}, 32'd0);
    check("mid_rst_cout", {31'b0, cout}, 32'd0);
    check("mid_rst_ovf", {31'b0, ovf}, 32'd0);
    tick(2);
    RSTn = 1'b1;
    sv = 0;
    for (int n = 0; n < 6; n++) begin
      tick(1);
      if (out_valid) sv++;
    end
    check("no_stale", sv, 32'd0);
    drive(16'h1234, 16'h1111, 1'b0, 1'b1);
    in_valid = 1'b0;
    tick(2);
    check("fresh_early", {31'b0, out_valid}, 32'd0);
    tick(1);
    check("fresh_valid", {31'b0, out_valid}, 32'd1);
    check("fresh_sum", {16'b0, sum}, 32'h2346);
    wait_drain();

    // Single-stage 8-bit instance: registered output one cycle after accept.
    a8 = 8'h7F; b8 = 8'h01; in_valid8 = 1'b1;
    #1 check("w8_in_ready", {31'b0, in_ready8}, 32'd1);
    tick(1);
    in_valid8 = 1'b0;
    check("w8_valid", {31'b0, out_valid8}, 32'd1);
    check("w8_sum", {24'b0, sum8}, 32'h80);
    check("w8_ovf", {31'b0, ovf8}, 32'd1);
    check("w8_cout", {31'b0, cout8}, 32'd0);
    tick(1);
    check("w8_drained", {31'b0, out_valid8}, 32'd0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
